// File: rtl/mem_access_ctrl.sv
// Single-outstanding data-memory access controller: accepts one load/store at a time,
// drives registered memory strobes, and returns a registered response with range checking.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned ADDR_BITS    = 17,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        distinct,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic        r_mem_write;
  logic        r_mem_read;
  logic        r_distinct;

  logic        w_accept;
  logic        w_oor;
  logic [31:0] w_address_nxt;
  logic [31:0] w_write_data_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic        w_resp_err_nxt;

  assign w_accept = req_valid & r_ready;
  assign w_oor    = (req_addr >> ADDR_BITS) != 32'd0;

  assign req_ready  = r_ready;
  assign busy       = (r_state != IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign address    = r_address;
  assign write_data = r_write_data;
  assign MemWrite   = r_mem_write;
  assign MemRead    = r_mem_read;
  assign distinct   = r_distinct;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_oor)          w_state_nxt = RESP;
          else if (req_write) w_state_nxt = WR_ISSUE;
          else                w_state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: w_state_nxt = RD_WAIT;
      // <= guards against a zero count ever stalling the wait
      RD_WAIT:  if (r_cnt <= 3'd1) w_state_nxt = RESP;
      WR_ISSUE: w_state_nxt = RESP;
      RESP:     if (resp_ready) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_address_nxt    = r_address;
    w_write_data_nxt = r_write_data;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_cnt_nxt        = r_cnt;
    if (w_accept) begin
      w_address_nxt    = req_addr;
      w_write_data_nxt = req_write ? req_wdata : '0;
      w_resp_rdata_nxt = '0;
      w_resp_err_nxt   = w_oor;
    end
    case (r_state)
      RD_ISSUE: w_cnt_nxt = LAT;
      RD_WAIT: begin
        if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_resp_rdata_nxt = read_data;
      end
      default: ;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while in its state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_address    <= '0;
      r_write_data <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_distinct   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_ready      <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_address    <= w_address_nxt;
      r_write_data <= w_write_data_nxt;
      r_mem_write  <= (w_state_nxt == WR_ISSUE);
      r_mem_read   <= (w_state_nxt == RD_ISSUE);
      r_distinct   <= (w_state_nxt == WR_ISSUE);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each with a behavioural data memory whose read_data is correct only in its valid cycle.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_ready;

  logic        req_ready_a, resp_valid_a, resp_err_a, busy_a;
  logic        MemWrite_a, MemRead_a, distinct_a;
  logic [31:0] resp_rdata_a, address_a, write_data_a, read_data_a;

  logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
  logic        MemWrite_b, MemRead_b, distinct_b;
  logic [31:0] resp_rdata_b, address_b, write_data_b, read_data_b;

  logic [31:0] word_a = 32'h0;
  logic [31:0] word_b = 32'h0;
  int unsigned cnt_a = 0, cnt_b = 0;
  int unsigned rd_pulses_a = 0, wr_pulses_a = 0, ds_pulses_a = 0, bad_combo_a = 0;
  int unsigned rd_snap, wr_snap, ds_snap;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.ADDR_BITS(17), .READ_LATENCY(1)) u_a (
    .CLK(CLK), .reset(reset), .req_valid(req_valid_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a), .busy(busy_a), .address(address_a), .write_data(write_data_a),
    .MemWrite(MemWrite_a), .MemRead(MemRead_a), .distinct(distinct_a), .read_data(read_data_a)
  );

  mem_access_ctrl #(.ADDR_BITS(17), .READ_LATENCY(3)) u_b (
    .CLK(CLK), .reset(reset), .req_valid(req_valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .busy(busy_b), .address(address_b), .write_data(write_data_b),
    .MemWrite(MemWrite_b), .MemRead(MemRead_b), .distinct(distinct_b), .read_data(read_data_b)
  );

  // Memory samples MemRead on an edge; data is valid only in the READ_LATENCY-th cycle after it.
  always @(posedge CLK) begin
    cnt_a <= MemRead_a ? 1 : ((cnt_a != 0) ? cnt_a - 1 : 0);
    cnt_b <= MemRead_b ? 3 : ((cnt_b != 0) ? cnt_b - 1 : 0);
    if (MemRead_a)                 rd_pulses_a <= rd_pulses_a + 1;
    if (MemWrite_a)                wr_pulses_a <= wr_pulses_a + 1;
    if (distinct_a)                ds_pulses_a <= ds_pulses_a + 1;
    if ((MemRead_a && MemWrite_a) || (distinct_a && !MemWrite_a))
      bad_combo_a <= bad_combo_a + 1;
  end

  assign read_data_a = (cnt_a == 1) ? word_a : 32'hBAD0BAD0;
  assign read_data_b = (cnt_b == 1) ? word_b : 32'hBAD0BAD0;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rd_snap = rd_pulses_a;
    wr_snap = wr_pulses_a;
    ds_snap = ds_pulses_a;
  endtask

  initial begin
    reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    step();
    chk1 ("rst_busy",      busy_a, 1'b0);
    chk1 ("rst_resp_valid", resp_valid_a, 1'b0);
    chk1 ("rst_memread",   MemRead_a, 1'b0);
    chk1 ("rst_memwrite",  MemWrite_a, 1'b0);
    chk32("rst_address",   address_a, 32'h0);
    chk32("rst_rdata",     resp_rdata_a, 32'h0);
    reset = 1'b0;
    step();
    chk1 ("rdy_after_rst", req_ready_a, 1'b1);

    // Load 0x10, latency 1
    word_a = 32'hDEADBEEF; snap();
    req_valid_a = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    step();
    req_valid_a = 1'b0; req_write = 1'b1; req_addr = 32'hFFFF_FFFF;
    chk1 ("ld_memread_c1",  MemRead_a, 1'b1);
    chk32("ld_addr_c1",     address_a, 32'h10);
    chk1 ("ld_busy_c1",     busy_a, 1'b1);
    chk1 ("ld_rdy_c1",      req_ready_a, 1'b0);
    step();
    chk1 ("ld_memread_c2",  MemRead_a, 1'b0);
    chk1 ("ld_rvalid_c2",   resp_valid_a, 1'b0);
    step();
    chk1 ("ld_rvalid_c3",   resp_valid_a, 1'b1);
    chk32("ld_rdata_c3",    resp_rdata_a, 32'hDEADBEEF);
    chk1 ("ld_err_c3",      resp_err_a, 1'b0);
    step();
    chk1 ("ld_rvalid_c4",   resp_valid_a, 1'b0);
    chk1 ("ld_rdy_c4",      req_ready_a, 1'b1);
    chk32("ld_rd_pulses",   rd_pulses_a - rd_snap, 32'd1);

    // Store 0x20
    snap();
    req_valid_a = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    step();
    req_valid_a = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    chk1 ("st_memwrite_c1", MemWrite_a, 1'b1);
    chk1 ("st_distinct_c1", distinct_a, 1'b1);
    chk1 ("st_memread_c1",  MemRead_a, 1'b0);
    chk32("st_addr_c1",     address_a, 32'h20);
    chk32("st_wdata_c1",    write_data_a, 32'h12345678);
    step();
    chk1 ("st_rvalid_c2",   resp_valid_a, 1'b1);
    chk32("st_rdata_c2",    resp_rdata_a, 32'h0);
    chk1 ("st_memwrite_c2", MemWrite_a, 1'b0);
    step();
    chk1 ("st_rvalid_c3",   resp_valid_a, 1'b0);
    chk32("st_wr_pulses",   wr_pulses_a - wr_snap, 32'd1);
    chk32("st_ds_pulses",   ds_pulses_a - ds_snap, 32'd1);

    // Out-of-range load 0x20000
    snap();
    req_valid_a = 1'b1; req_write = 1'b0; req_addr = 32'h0002_0000;
    step();
    req_valid_a = 1'b0;
    chk1 ("oor_rvalid_c1",  resp_valid_a, 1'b1);
    chk1 ("oor_err_c1",     resp_err_a, 1'b1);
    chk32("oor_rdata_c1",   resp_rdata_a, 32'h0);
    step();
    chk1 ("oor_rvalid_c2",  resp_valid_a, 1'b0);

    // Out-of-range store 0x80000000
    req_valid_a = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h1;
    step();
    req_valid_a = 1'b0;
    chk1 ("oors_err_c1",    resp_err_a, 1'b1);
    step();
    chk32("oor_rd_pulses",  rd_pulses_a - rd_snap, 32'd0);
    chk32("oor_wr_pulses",  wr_pulses_a - wr_snap, 32'd0);

    // Response held for 5 cycles, then a request pending across the handshake edge
    word_a = 32'hCAFEF00D; resp_ready = 1'b0;
    req_valid_a = 1'b1; req_write = 1'b0; req_addr = 32'h44;
    step();
    req_valid_a = 1'b0;
    step();
    step();
    chk1 ("hold_rvalid_c3", resp_valid_a, 1'b1);
    chk32("hold_rdata_c3",  resp_rdata_a, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1 ("hold_rvalid",  resp_valid_a, 1'b1);
      chk32("hold_rdata",   resp_rdata_a, 32'hCAFEF00D);
      chk1 ("hold_rdy",     req_ready_a, 1'b0);
    end
    resp_ready = 1'b1;
    req_valid_a = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADCAFE;
    step();
    chk1 ("hs_rvalid",      resp_valid_a, 1'b0);
    chk1 ("hs_busy",        busy_a, 1'b0);
    chk1 ("hs_rdy",         req_ready_a, 1'b1);
    step();
    req_valid_a = 1'b0;
    chk1 ("b2b_memwrite",   MemWrite_a, 1'b1);
    chk32("b2b_addr",       address_a, 32'h30);
    step();
    chk1 ("b2b_rvalid",     resp_valid_a, 1'b1);
    step();

    // Reset during RD_WAIT
    snap();
    word_a = 32'h55AA55AA;
    req_valid_a = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    step();
    req_valid_a = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk1 ("ar_busy",        busy_a, 1'b0);
    chk1 ("ar_memread",     MemRead_a, 1'b0);
    chk1 ("ar_rvalid",      resp_valid_a, 1'b0);
    chk32("ar_addr",        address_a, 32'h0);
    chk32("ar_rdata",       resp_rdata_a, 32'h0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk1 ("ar_no_resp",     resp_valid_a, 1'b0);
    chk1 ("ar_rdy",         req_ready_a, 1'b1);
    chk32("ar_wr_pulses",   wr_pulses_a - wr_snap, 32'd0);
    word_a = 32'hDEADBEEF;
    req_valid_a = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    step();
    req_valid_a = 1'b0;
    step();
    step();
    chk1 ("ar_ld_rvalid",   resp_valid_a, 1'b1);
    chk32("ar_ld_rdata",    resp_rdata_a, 32'hDEADBEEF);
    step();

    // Latency-3 instance, top in-range address
    word_b = 32'h5A5AA5A5;
    req_valid_b = 1'b1; req_write = 1'b0; req_addr = 32'h0001_FFFF;
    step();
    req_valid_b = 1'b0; req_addr = 32'h0;
    chk1 ("l3_memread_c1",  MemRead_b, 1'b1);
    chk32("l3_addr_c1",     address_b, 32'h0001_FFFF);
    step();
    step();
    step();
    chk1 ("l3_rvalid_c4",   resp_valid_b, 1'b0);
    chk1 ("l3_busy_c4",     busy_b, 1'b1);
    step();
    chk1 ("l3_rvalid_c5",   resp_valid_b, 1'b1);
    chk32("l3_rdata_c5",    resp_rdata_b, 32'h5A5AA5A5);
    chk1 ("l3_err_c5",      resp_err_b, 1'b0);
    step();
    chk1 ("l3_rvalid_c6",   resp_valid_b, 1'b0);

    chk32("strobe_combo",   bad_combo_a, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
